elf_keypad: RTL and testbench
=============================

Name: elf_keypad

Overview:
- Converts PS/2 key events into the front-panel controls of the COSMAC ELF core: 8-bit data toggle switches, INPUT push-button, LOAD/RUN/MP switches.
- Sits directly upstream of the ELF core, in the same clock domain as the core.
- Consumes the toggle-strobe PS/2 key word that the platform delivers (ps2_key[10] toggles once per event).
- Hex keys shift nibbles into the data byte. Enter drives INPUT with a guaranteed minimum low time. Letter keys toggle the mode switches.

Parameters:
- IN_MIN_CYCLES, 48000: minimum number of clk cycles in_n stays low after Enter is released (1 ms at 48 MHz); must be ≥1.
- CNT_W, 16: width of the hold counter; must satisfy 2^CNT_W > IN_MIN_CYCLES.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_key  in  11  [10] event toggle, [9] 1=press/0=release, [8] extended, [7:0] set-2 scancode.
- data_sw  out  8  data toggle switches to ELF input port.
- in_n  out  1  INPUT button, active low.
- load_sw  out  1  LOAD switch.
- run_sw  out  1  RUN switch.
- mp_sw  out  1  memory-protect switch.
- key_evt  out  1  one-cycle pulse per accepted (decoded) key event.

Behaviour:
- Reset values: data_sw=8'h00, in_n=1, load_sw=0, run_sw=0, mp_sw=0, key_evt=0; FSM=IDLE; hold counter=0; armed=0.
- Strobe detection:
  - The first clk after reset deassertion sets armed=1 and loads prev_tog<=ps2_key[10]. No event is generated on that cycle.
  - After that, an event occurs on a cycle where ps2_key[10]!=prev_tog. On that cycle, prev_tog is updated and ps2_key[9:0] is captured into evt_reg.
  - Decode and output update happen on the next cycle, so latency is 2 clk from the toggle edge to the output change. key_evt pulses on that same output-update cycle.
- Events with extended=1 are ignored entirely: no key_evt, no state change.
- Hex keys, press only: 0..9 = 45,16,1E,26,25,2E,36,3D,3E,46; A..F = 1C,32,21,23,24,2B.
  - Action: data_sw <= {data_sw[3:0], nibble}.
- Backspace (66), press: data_sw <= 8'h00.
- L (4B), press: load_sw toggles. R (2D), press: run_sw toggles. M (3A), press: mp_sw toggles.
- Releases of hex, Backspace, L, R and M keys: no state change, no key_evt.
- Unlisted scancodes: ignored, no key_evt.
- INPUT FSM (Enter = 5A):
  - IDLE (in_n=1): Enter press → HELD.
  - HELD (in_n=0): Enter release → HOLD (counter<=0). A repeated Enter press (typematic) stays in HELD.
  - HOLD (in_n=0): counter increments each cycle. When counter==IN_MIN_CYCLES-1 → IDLE, and in_n=1 on the following cycle. An Enter press during HOLD → HELD, counter cleared.
  - Enter press and release both produce key_evt.
  - in_n is registered and changes on the decode cycle, so in_n falls 2 clk after the press toggle.
- At most one event per cycle by construction. A toggle arriving on the decode cycle of the previous event is captured normally, giving back-to-back events on consecutive cycles with no loss.
- Two toggles within one cycle cannot be distinguished. The upstream source guarantees ≥2 clk spacing.
- reset_n asserted mid-operation, including during HOLD: all state returns to reset values immediately. After release, armed re-sync suppresses a spurious event even if ps2_key[10]=1.
- Counter saturation is not reachable, given the CNT_W constraint.

Test Plan:
- Reset with ps2_key[10]=1, release reset, hold input for 5 clk → no key_evt; all outputs remain at reset values.
- Press '1' (16), then press 'F' (2B), toggles 10 clk apart → data_sw 00→01→1F; each change 2 clk after its toggle; 2 key_evt pulses. Then Backspace → 00.
- Press 'L' twice, 'R' once, 'M' once (press events only, plus a release of L) → load_sw ends 0, run_sw 1, mp_sw 1; the release causes no key_evt.
- IN_MIN_CYCLES=8: Enter press at t0, release at t0+3 → in_n low from t0+2 and high at t0+5+8. Second run: re-press during HOLD → in_n stays low, and the timer restarts from the new release.
- Extended event (ps2_key[8]=1, code 5A press) → no in_n change, no key_evt. Unmapped code 1A → ignored.
- Assert reset_n mid-HOLD with data_sw=3C and run_sw=1 → all outputs reset asynchronously within the same cycle. Then back-to-back toggles on consecutive cycles ('2' then '3') → data_sw=23, with 2 key_evt pulses on consecutive cycles.

Source files
------------

// File: rtl/elf_keypad.sv
// Maps PS/2 key events onto the COSMAC ELF front panel: data switches, INPUT button, LOAD/RUN/MP.
// Latency: outputs and key_evt update 2 clk after the ps2_key[10] toggle edge.
// No backpressure: one event per toggle is absorbed every cycle, back-to-back toggles are not lost.
module elf_keypad #(
   parameter int IN_MIN_CYCLES = 48000,
   parameter int CNT_W         = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   output logic [7:0]  data_sw,
   output logic        in_n,
   output logic        load_sw,
   output logic        run_sw,
   output logic        mp_sw,
   output logic        key_evt
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(IN_MIN_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      HOLD = 2'd2
   } in_state_t;

   logic             armed;
   logic             prev_tog;
   logic             evt_vld;
   logic [9:0]       evt_reg;

   logic             evt_press;
   logic             evt_ext;
   logic [7:0]       evt_code;
   logic             is_hex;
   logic [3:0]       nibble;

   logic             live;
   logic             hex_press;
   logic             bksp_press;
   logic             l_press;
   logic             r_press;
   logic             m_press;
   logic             enter_press;
   logic             enter_rel;
   logic             accepted;

   in_state_t        state;
   in_state_t        state_nxt;
   logic [CNT_W-1:0] hold_cnt;

   // Strobe detection: first cycle after reset only syncs to the current toggle level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed    <= 1'b0;
         prev_tog <= 1'b0;
         evt_vld  <= 1'b0;
         evt_reg  <= 10'h000;
      end else if (!armed) begin
         armed    <= 1'b1;
         prev_tog <= ps2_key[10];
         evt_vld  <= 1'b0;
      end else if (ps2_key[10] != prev_tog) begin
         prev_tog <= ps2_key[10];
         evt_reg  <= ps2_key[9:0];
         evt_vld  <= 1'b1;
      end else begin
         evt_vld  <= 1'b0;
      end
   end

   assign evt_press = evt_reg[9];
   assign evt_ext   = evt_reg[8];
   assign evt_code  = evt_reg[7:0];

   // Set-2 scancode to hex nibble lookup
   always_comb begin
      is_hex = 1'b1;
      nibble = 4'h0;
      case (evt_code)
         8'h45: nibble = 4'h0;
         8'h16: nibble = 4'h1;
         8'h1E: nibble = 4'h2;
         8'h26: nibble = 4'h3;
         8'h25: nibble = 4'h4;
         8'h2E: nibble = 4'h5;
         8'h36: nibble = 4'h6;
         8'h3D: nibble = 4'h7;
         8'h3E: nibble = 4'h8;
         8'h46: nibble = 4'h9;
         8'h1C: nibble = 4'hA;
         8'h32: nibble = 4'hB;
         8'h21: nibble = 4'hC;
         8'h23: nibble = 4'hD;
         8'h24: nibble = 4'hE;
         8'h2B: nibble = 4'hF;
         default: is_hex = 1'b0;
      endcase
   end

   // Extended-prefix events are dropped before any decoding
   assign live        = evt_vld && !evt_ext;
   assign hex_press   = live && evt_press && is_hex;
   assign bksp_press  = live && evt_press && (evt_code == 8'h66);
   assign l_press     = live && evt_press && (evt_code == 8'h4B);
   assign r_press     = live && evt_press && (evt_code == 8'h2D);
   assign m_press     = live && evt_press && (evt_code == 8'h3A);
   assign enter_press = live && evt_press && (evt_code == 8'h5A);
   assign enter_rel   = live && !evt_press && (evt_code == 8'h5A);
   assign accepted    = hex_press || bksp_press || l_press || r_press || m_press ||
                        enter_press || enter_rel;

   // Front-panel switch registers and the accepted-event pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_sw <= 8'h00;
         load_sw <= 1'b0;
         run_sw  <= 1'b0;
         mp_sw   <= 1'b0;
         key_evt <= 1'b0;
      end else begin
         key_evt <= accepted;
         if (hex_press) begin
            data_sw <= {data_sw[3:0], nibble};
         end else if (bksp_press) begin
            data_sw <= 8'h00;
         end
         if (l_press) load_sw <= ~load_sw;
         if (r_press) run_sw  <= ~run_sw;
         if (m_press) mp_sw   <= ~mp_sw;
      end
   end

   // INPUT FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // INPUT FSM next state: a fresh Enter press always wins over hold expiry
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (enter_press) state_nxt = HELD;
         HELD: if (enter_rel) state_nxt = HOLD;
         HOLD: begin
            if (enter_press) begin
               state_nxt = HELD;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Hold timer: restarts at zero on every entry into HOLD, idles at zero elsewhere
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_cnt <= '0;
      end else if (state_nxt != HOLD) begin
         hold_cnt <= '0;
      end else if (state == HOLD) begin
         hold_cnt <= hold_cnt + CNT_W'(1);
      end else begin
         hold_cnt <= '0;
      end
   end

   // INPUT button is pressed in every state except IDLE
   always_comb begin
      in_n = (state == IDLE);
   end

endmodule

// File: tb/tb_elf_keypad.sv
// Bench for elf_keypad: directed front-panel scenarios followed by randomized key traffic.
// Latency: compares every cycle on the falling edge against a two-edge-delayed event model.
// Backpressure: none; the bench paces toggles itself, down to consecutive cycles.
module tb_elf_keypad;

   localparam int N = 8;

   logic        clk;
   logic        reset_n;
   logic [10:0] ps2_key;
   logic [7:0]  data_sw;
   logic        in_n;
   logic        load_sw;
   logic        run_sw;
   logic        mp_sw;
   logic        key_evt;

   elf_keypad #(.IN_MIN_CYCLES(N), .CNT_W(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ps2_key (ps2_key),
      .data_sw (data_sw),
      .in_n    (in_n),
      .load_sw (load_sw),
      .run_sw  (run_sw),
      .mp_sw   (mp_sw),
      .key_evt (key_evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       vld;
      logic       prs;
      logic       ext;
      logic [7:0] code;
   } ev_t;

   logic [7:0] hex_codes [16];
   logic [7:0] pick_codes [8];

   // Model state: what the front panel should show, in spec terms
   logic [7:0] m_data;
   logic       m_load, m_run, m_mp, m_evt;
   logic       m_enter;   // Enter physically held (press seen, no release yet)
   int         m_rel;     // model cycle at which the last Enter release took effect
   int         mcyc;
   ev_t        pa, pb;    // event sent last edge / event captured by the DUT
   logic       tog;

   int checks;
   int passes;

   task automatic clear_model();
      m_data  = 8'h00;
      m_load  = 1'b0;
      m_run   = 1'b0;
      m_mp    = 1'b0;
      m_evt   = 1'b0;
      m_enter = 1'b0;
      m_rel   = -1000;
      pa      = '0;
      pb      = '0;
   endtask

   task automatic model_step();
      logic acc;
      ev_t  e;
      mcyc = mcyc + 1;
      if (!reset_n) begin
         clear_model();
      end else begin
         acc = 1'b0;
         e   = pb;
         if (e.vld && !e.ext) begin
            if (e.prs) begin
               for (int i = 0; i < 16; i++) begin
                  if (hex_codes[i] == e.code) begin
                     m_data = {m_data[3:0], 4'(i)};
                     acc = 1'b1;
                  end
               end
               if (e.code == 8'h66) begin m_data = 8'h00; acc = 1'b1; end
               if (e.code == 8'h4B) begin m_load = ~m_load; acc = 1'b1; end
               if (e.code == 8'h2D) begin m_run  = ~m_run;  acc = 1'b1; end
               if (e.code == 8'h3A) begin m_mp   = ~m_mp;   acc = 1'b1; end
               if (e.code == 8'h5A) begin m_enter = 1'b1;   acc = 1'b1; end
            end else if (e.code == 8'h5A) begin
               acc = 1'b1;
               if (m_enter) begin
                  m_enter = 1'b0;
                  m_rel   = mcyc;
               end
            end
         end
         m_evt = acc;
         pb = pa;
         pa = '0;
      end
   endtask

   task automatic compare();
      logic       exp_in_n;
      logic [12:0] got, exp;
      exp_in_n = !(m_enter || (mcyc < m_rel + N));
      exp = {m_data, exp_in_n, m_load, m_run, m_mp, m_evt};
      got = {data_sw, in_n, load_sw, run_sw, mp_sw, key_evt};
      checks++;
      if (got !== exp) begin
         $display("FAIL cycle_cmp t=%0t {data,in_n,load,run,mp,evt} got=%h exp=%h", $time, got, exp);
      end else begin
         passes++;
      end
   endtask

   task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end else begin
         passes++;
      end
   endtask

   task automatic step(input logic go, input logic prs, input logic ext, input logic [7:0] code);
      @(posedge clk);
      model_step();
      #1;
      if (go) begin
         tog = ~tog;
         ps2_key = {tog, prs, ext, code};
         pa = '{vld: 1'b1, prs: prs, ext: ext, code: code};
      end
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic send(input logic prs, input logic ext, input logic [7:0] code, input int gap);
      step(1'b1, prs, ext, code);
      idle(gap);
   endtask

   task automatic release_reset();
      @(posedge clk);
      model_step();
      #1 reset_n = 1'b1;
      @(negedge clk);
      compare();
   endtask

   task automatic assert_reset_mid();
      #2 reset_n = 1'b0;
      #1;
      lit("rst_data_sw", data_sw, 8'h00);
      lit("rst_in_n",    {7'd0, in_n},    8'h01);
      lit("rst_load_sw", {7'd0, load_sw}, 8'h00);
      lit("rst_run_sw",  {7'd0, run_sw},  8'h00);
      lit("rst_mp_sw",   {7'd0, mp_sw},   8'h00);
      lit("rst_key_evt", {7'd0, key_evt}, 8'h00);
      clear_model();
   endtask

   initial begin
      hex_codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                    8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
      pick_codes = '{8'h66, 8'h4B, 8'h2D, 8'h3A, 8'h5A, 8'h5A, 8'h1A, 8'h00};
      checks  = 0;
      passes  = 0;
      mcyc    = 0;
      tog     = 1'b1;
      reset_n = 1'b0;
      ps2_key = 11'h400;
      clear_model();

      // Reset with toggle bit high, then release: no spurious event
      idle(3);
      lit("reset_data_sw", data_sw, 8'h00);
      lit("reset_in_n", {7'd0, in_n}, 8'h01);
      release_reset();
      idle(5);
      lit("armed_no_evt_data", data_sw, 8'h00);

      // '1' then 'F' ten cycles apart, then Backspace
      step(1'b1, 1'b1, 1'b0, 8'h16);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      lit("data_before_latency", data_sw, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      lit("data_after_1", data_sw, 8'h01);
      lit("evt_after_1", {7'd0, key_evt}, 8'h01);
      idle(7);
      send(1'b1, 1'b0, 8'h2B, 2);
      lit("data_after_F", data_sw, 8'h1F);
      send(1'b1, 1'b0, 8'h66, 2);
      lit("data_after_bksp", data_sw, 8'h00);

      // Mode switches, including an L release that must be ignored
      send(1'b1, 1'b0, 8'h4B, 3);
      send(1'b0, 1'b0, 8'h4B, 3);
      send(1'b1, 1'b0, 8'h4B, 3);
      send(1'b1, 1'b0, 8'h2D, 3);
      send(1'b1, 1'b0, 8'h3A, 3);
      lit("load_sw_end", {7'd0, load_sw}, 8'h00);
      lit("run_sw_end",  {7'd0, run_sw},  8'h01);
      lit("mp_sw_end",   {7'd0, mp_sw},   8'h01);

      // Enter press at t0, release at t0+3: low from t0+2, high at t0+13
      step(1'b1, 1'b1, 1'b0, 8'h5A);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      lit("in_n_t1", {7'd0, in_n}, 8'h01);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      lit("in_n_t2", {7'd0, in_n}, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h5A);
      idle(9);
      lit("in_n_t12", {7'd0, in_n}, 8'h00);
      idle(1);
      lit("in_n_t13", {7'd0, in_n}, 8'h01);
      idle(3);

      // Re-press during HOLD: timer restarts from the second release
      send(1'b1, 1'b0, 8'h5A, 2);
      send(1'b0, 1'b0, 8'h5A, 4);
      send(1'b1, 1'b0, 8'h5A, 1);
      send(1'b0, 1'b0, 8'h5A, 3);
      lit("in_n_retrig_t13", {7'd0, in_n}, 8'h00);
      idle(6);
      lit("in_n_retrig_t19", {7'd0, in_n}, 8'h00);
      idle(1);
      lit("in_n_retrig_t20", {7'd0, in_n}, 8'h01);

      // Extended Enter and an unmapped code are ignored
      send(1'b1, 1'b1, 8'h5A, 3);
      lit("ext_in_n", {7'd0, in_n}, 8'h01);
      send(1'b1, 1'b0, 8'h1A, 3);
      lit("unmapped_data", data_sw, 8'h00);

      // Data 3C, run on, reset in the middle of HOLD
      send(1'b1, 1'b0, 8'h26, 2);
      send(1'b1, 1'b0, 8'h21, 2);
      lit("data_3C", data_sw, 8'h3C);
      send(1'b1, 1'b0, 8'h5A, 2);
      send(1'b0, 1'b0, 8'h5A, 5);
      lit("in_n_mid_hold", {7'd0, in_n}, 8'h00);
      assert_reset_mid();
      idle(2);
      release_reset();
      idle(3);

      // Back-to-back toggles on consecutive cycles: '2' then '3'
      step(1'b1, 1'b1, 1'b0, 8'h1E);
      step(1'b1, 1'b1, 1'b0, 8'h26);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      lit("b2b_evt1", {7'd0, key_evt}, 8'h01);
      lit("b2b_data1", data_sw, 8'h02);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      lit("b2b_evt2", {7'd0, key_evt}, 8'h01);
      lit("b2b_data2", data_sw, 8'h23);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      lit("b2b_evt_end", {7'd0, key_evt}, 8'h00);

      // Randomized traffic checked cycle by cycle against the model
      for (int n = 0; n < 3000; n++) begin
         int   r;
         logic [7:0] code;
         logic prs, ext;
         r    = int'($urandom_range(0, 23));
         code = (r < 16) ? hex_codes[r] : pick_codes[r - 16];
         prs  = ($urandom_range(0, 9) < 7);
         ext  = ($urandom_range(0, 7) == 0);
         send(prs, ext, code, int'($urandom_range(0, 3)));
         if (n == 1500) begin
            assert_reset_mid();
            idle(2);
            release_reset();
            idle(2);
         end
      end
      idle(N + 4);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
